// File: rtl/axis_slaver_sink_if.sv
// axi_stream_inf: AXI-stream bundle shared by the stream producers and consumers.
// Latency: none, wires only.
// Backpressure: tready flows from slaver to master; a beat moves when tvalid & tready.
interface axi_stream_inf #(
  parameter int DSIZE = 32,
  parameter int KSIZE = DSIZE / 8,
  parameter int USIZE = 1
) (
  input logic aclk,
  input logic aresetn
);

  logic             tvalid;
  logic             tready;
  logic [DSIZE-1:0] tdata;
  logic [KSIZE-1:0] tkeep;
  logic             tlast;
  logic [USIZE-1:0] tuser;

  modport slaver (
    input  aclk,
    input  aresetn,
    input  tvalid,
    input  tdata,
    input  tkeep,
    input  tlast,
    input  tuser,
    output tready
  );

  modport master (
    input  aclk,
    input  aresetn,
    input  tready,
    output tvalid,
    output tdata,
    output tkeep,
    output tlast,
    output tuser
  );

endinterface

// File: rtl/axis_slaver_sink.sv
// axis_slaver_sink: consumes an AXI stream and keeps beat/byte/packet/user statistics.
// Latency: statistics and last_pkt_len update 1 cycle after acceptance; pkt_done pulses the cycle after a tlast beat.
// Backpressure: tready is registered from sink_en and an 8-phase rotating ready_pattern, never from tvalid.
module axis_slaver_sink #(
  parameter int CNT_W = 32,
  parameter int LEN_W = 16
) (
  axi_stream_inf.slaver    slaver,
  input  logic             sink_en,
  input  logic [7:0]       ready_pattern,
  input  logic             clear,
  output logic [CNT_W-1:0] beat_cnt,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] user_cnt,
  output logic [LEN_W-1:0] last_pkt_len,
  output logic             pkt_done,
  output logic             in_pkt
);

  localparam int KSIZE = $bits(slaver.tkeep);
  localparam int PW    = $clog2(KSIZE + 1);
  localparam int SW    = ((CNT_W > PW) ? CNT_W : PW) + 1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PKT  = 1'b1
  } state_t;

  logic             clk;
  logic             rst_n;
  logic [2:0]       phase;
  logic             armed;
  logic             tready_q;
  logic             acc;
  logic             acc_last;
  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] cur_len;
  logic [LEN_W-1:0] len_nxt;
  logic [PW-1:0]    keep_pop;
  logic [SW-1:0]    byte_sum;
  logic [CNT_W-1:0] byte_nxt;

  // tdata is consumed and discarded; upper tuser bits carry nothing for us
  logic unused_payload;
  assign unused_payload = ^{slaver.tdata, slaver.tuser};

  assign clk   = slaver.aclk;
  assign rst_n = slaver.aresetn;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // A beat is accepted only on a real handshake
  assign acc           = slaver.tvalid & tready_q;
  assign acc_last      = acc & slaver.tlast;
  assign slaver.tready = tready_q;

  // Rotate the backpressure phase and register tready; armed holds tready low
  // for the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= 3'd0;
      armed    <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      armed    <= 1'b1;
      tready_q <= armed & sink_en & ready_pattern[phase];
      if (sink_en) begin
        phase <= phase + 3'd1;
      end
    end
  end

  // Number of valid bytes in the current beat
  always_comb begin
    keep_pop = '0;
    for (int i = 0; i < KSIZE; i++) begin
      keep_pop = keep_pop + PW'(slaver.tkeep[i]);
    end
  end

  // Saturating byte accumulation, done one bit wider so overflow is visible
  always_comb begin
    byte_sum = SW'(byte_cnt) + SW'(keep_pop);
    if (byte_sum > SW'(CNT_MAX)) begin
      byte_nxt = CNT_MAX;
    end else begin
      byte_nxt = byte_sum[CNT_W-1:0];
    end
  end

  // Packet length including the beat being accepted now
  always_comb begin
    if (state == S_IDLE) begin
      len_nxt = LEN_W'(1);
    end else if (cur_len == LEN_MAX) begin
      len_nxt = LEN_MAX;
    end else begin
      len_nxt = cur_len + LEN_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: open on a non-last beat, close on a last beat
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (acc && !slaver.tlast) state_nxt = S_PKT;
      S_PKT:   if (acc_last)             state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_pkt = (state == S_PKT);
  end

  // Running length of the packet in flight; unaffected by clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_len <= '0;
    end else if (acc) begin
      cur_len <= len_nxt;
    end
  end

  // Packet-end pulse, independent of clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= acc_last;
    end
  end

  // Statistics; clear wins over a beat accepted in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt     <= '0;
      byte_cnt     <= '0;
      pkt_cnt      <= '0;
      user_cnt     <= '0;
      last_pkt_len <= '0;
    end else if (clear) begin
      beat_cnt     <= '0;
      byte_cnt     <= '0;
      pkt_cnt      <= '0;
      user_cnt     <= '0;
      last_pkt_len <= '0;
    end else if (acc) begin
      beat_cnt <= sat_inc(beat_cnt);
      byte_cnt <= byte_nxt;
      if (slaver.tuser[0]) begin
        user_cnt <= sat_inc(user_cnt);
      end
      if (slaver.tlast) begin
        pkt_cnt      <= sat_inc(pkt_cnt);
        last_pkt_len <= len_nxt;
      end
    end
  end

endmodule

// File: tb/tb_axis_slaver_sink.sv
// tb_axis_slaver_sink: randomized scoreboard bench for axis_slaver_sink.
// Latency: expected records queued at acceptance, popped on each pkt_done pulse.
// Backpressure: a reference model predicts tready every cycle.
module tb_axis_slaver_sink;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_stream_inf #(.DSIZE(32)) ifm (.aclk(clk), .aresetn(rst_n));
  axi_stream_inf #(.DSIZE(32)) ifs (.aclk(clk), .aresetn(rst_n));

  logic        sink_en = 1'b0;
  logic [7:0]  pattern = 8'h00;
  logic        clear   = 1'b0;
  logic        clear_s = 1'b0;

  logic [31:0] beat_cnt, byte_cnt, pkt_cnt, user_cnt;
  logic [15:0] last_pkt_len;
  logic        pkt_done, in_pkt;
  logic [3:0]  s_beat_cnt, s_byte_cnt, s_pkt_cnt, s_user_cnt;
  logic [15:0] s_last_pkt_len;
  logic        s_pkt_done, s_in_pkt;

  axis_slaver_sink #(.CNT_W(32), .LEN_W(16)) dut (
    .slaver(ifm.slaver), .sink_en(sink_en), .ready_pattern(pattern), .clear(clear),
    .beat_cnt(beat_cnt), .byte_cnt(byte_cnt), .pkt_cnt(pkt_cnt), .user_cnt(user_cnt),
    .last_pkt_len(last_pkt_len), .pkt_done(pkt_done), .in_pkt(in_pkt)
  );

  axis_slaver_sink #(.CNT_W(4), .LEN_W(16)) dut_s (
    .slaver(ifs.slaver), .sink_en(sink_en), .ready_pattern(pattern), .clear(clear_s),
    .beat_cnt(s_beat_cnt), .byte_cnt(s_byte_cnt), .pkt_cnt(s_pkt_cnt), .user_cnt(s_user_cnt),
    .last_pkt_len(s_last_pkt_len), .pkt_done(s_pkt_done), .in_pkt(s_in_pkt)
  );

  // The saturation instance sees the same stream as the main one
  assign ifs.tvalid = ifm.tvalid;
  assign ifs.tdata  = ifm.tdata;
  assign ifs.tkeep  = ifm.tkeep;
  assign ifs.tlast  = ifm.tlast;
  assign ifs.tuser  = ifm.tuser;

  typedef struct {
    int pkts;
    int len;
    int beats;
    int bytes;
    int users;
  } exp_t;

  exp_t sbq[$];

  int nchecks = 0;
  int nerr    = 0;
  int pulses  = 0;

  // reference model state
  int m_beats, m_bytes, m_pkts, m_users, m_last, m_cur_len;
  bit m_in_pkt;
  int s_beats, s_bytes, s_pkts, s_users;
  int edges, en_seen;
  bit exp_rdy;

  task automatic chk(input string name, input longint act, input longint exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int min15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_reset();
    m_beats = 0; m_bytes = 0; m_pkts = 0; m_users = 0; m_last = 0; m_cur_len = 0;
    m_in_pkt = 1'b0;
    s_beats = 0; s_bytes = 0; s_pkts = 0; s_users = 0;
  endtask

  // Called right after the edge at which a beat was accepted
  task automatic model_accept(input logic [3:0] keep, input bit last, input bit user);
    exp_t e;
    int   len_now;
    len_now   = m_in_pkt ? m_cur_len + 1 : 1;
    m_cur_len = len_now;
    m_in_pkt  = !last;
    s_beats++;
    s_bytes += $countones(keep);
    if (user) s_users++;
    if (last) s_pkts++;
    if (clear) begin
      m_beats = 0; m_bytes = 0; m_pkts = 0; m_users = 0; m_last = 0;
    end else begin
      m_beats++;
      m_bytes += $countones(keep);
      if (user) m_users++;
      if (last) begin
        m_pkts++;
        m_last = len_now;
      end
    end
    if (last) begin
      e.pkts = m_pkts; e.len = m_last; e.beats = m_beats; e.bytes = m_bytes; e.users = m_users;
      sbq.push_back(e);
    end
  endtask

  // tready prediction: low for the first edge after release, then the
  // pattern bit chosen by how many enabled cycles have elapsed
  always @(posedge clk) begin
    if (!rst_n) begin
      edges   = 0;
      en_seen = 0;
      exp_rdy = 1'b0;
    end else begin
      exp_rdy = (edges >= 1) && sink_en && pattern[en_seen % 8];
      edges++;
      if (sink_en) en_seen++;
    end
  end

  // Monitor: tready every cycle, scoreboard pop on every pkt_done
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("tready_in_reset", ifm.tready, 0);
    end else begin
      chk("tready_model", ifm.tready, exp_rdy);
    end
    if (pkt_done) begin
      pulses++;
      if (sbq.size() == 0) begin
        nchecks++;
        nerr++;
        $display("FAIL pkt_done_unexpected: got pulse expected none at %0t", $time);
      end else begin
        e = sbq.pop_front();
        chk("mon_pkt_cnt", pkt_cnt, e.pkts);
        chk("mon_last_pkt_len", last_pkt_len, e.len);
        chk("mon_beat_cnt", beat_cnt, e.beats);
        chk("mon_byte_cnt", byte_cnt, e.bytes);
        chk("mon_user_cnt", user_cnt, e.users);
      end
    end
  end

  // Entered and left at posedge+1
  task automatic send_beat(input logic [3:0] keep, input bit last, input bit user);
    int waited = 0;
    bit done   = 1'b0;
    ifm.tvalid = 1'b1;
    ifm.tdata  = $urandom;
    ifm.tkeep  = keep;
    ifm.tlast  = last;
    ifm.tuser  = user;
    while (!done) begin
      @(negedge clk);
      if (ifm.tready) begin
        @(posedge clk);
        model_accept(keep, last, user);
        done = 1'b1;
      end else begin
        waited++;
        @(posedge clk);
        if (waited > 50) begin
          nchecks++;
          nerr++;
          $display("FAIL beat_timeout: got no tready expected handshake within 50 cycles at %0t", $time);
          done = 1'b1;
        end
      end
    end
    #1;
    ifm.tvalid = 1'b0;
  endtask

  task automatic check_totals(input string tag);
    @(negedge clk);
    chk({tag, "_beat_cnt"}, beat_cnt, m_beats);
    chk({tag, "_byte_cnt"}, byte_cnt, m_bytes);
    chk({tag, "_pkt_cnt"}, pkt_cnt, m_pkts);
    chk({tag, "_user_cnt"}, user_cnt, m_users);
    chk({tag, "_last_len"}, last_pkt_len, m_last);
    chk({tag, "_in_pkt"}, in_pkt, m_in_pkt);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    m_beats = 0; m_bytes = 0; m_pkts = 0; m_users = 0; m_last = 0;
    #1;
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r, prev;
    int acc;
    model_reset();
    ifm.tvalid = 1'b0; ifm.tdata = '0; ifm.tkeep = '0; ifm.tlast = 1'b0; ifm.tuser = '0;
    sink_en = 1'b1;
    pattern = 8'hFF;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_last_len", last_pkt_len, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_in_pkt", in_pkt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("tready_first_edge", ifm.tready, 0);
    @(posedge clk);
    #1;

    // three 4-beat packets, full keep
    pulses = 0;
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 4; b++) send_beat(4'hF, b == 3, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    check_totals("pkts3x4");
    chk("pkts3x4_beats", beat_cnt, 12);
    chk("pkts3x4_bytes", byte_cnt, 48);
    chk("pkts3x4_pkts", pkt_cnt, 3);
    chk("pkts3x4_len", last_pkt_len, 4);
    chk("pkts3x4_pulses", pulses, 3);

    // alternating backpressure with tvalid held high
    pattern = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    ifm.tvalid = 1'b1; ifm.tkeep = 4'hF; ifm.tlast = 1'b0; ifm.tuser = '0;
    prev = 1'b0;
    for (int w = 0; w < 2; w++) begin
      acc = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        r = ifm.tready;
        if (w != 0 || c != 0) chk("p55_toggle", r, !prev);
        prev = r;
        if (r) acc++;
        @(posedge clk);
        if (r) model_accept(4'hF, 1'b0, 1'b0);
        #1;
        ifm.tdata = $urandom;
      end
      chk("p55_accepts_per_8", acc, 4);
    end
    ifm.tvalid = 1'b0;
    send_beat(4'hF, 1'b1, 1'b0);
    pattern = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check_totals("p55");

    // single-beat packet then a 2-beat packet with tuser on beat 2
    pulse_clear();
    send_beat(4'b0011, 1'b1, 1'b0);
    send_beat(4'hF, 1'b0, 1'b0);
    send_beat(4'hF, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_totals("short");
    chk("short_pkts", pkt_cnt, 2);
    chk("short_len", last_pkt_len, 2);
    chk("short_bytes", byte_cnt, 10);
    chk("short_users", user_cnt, 1);

    // clear coincident with the accepted tlast beat
    send_beat(4'hF, 1'b0, 1'b1);
    pulses = 0;
    clear = 1'b1;
    send_beat(4'hF, 1'b1, 1'b0);
    clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_totals("clr_last");
    chk("clr_last_pkts", pkt_cnt, 0);
    chk("clr_last_beats", beat_cnt, 0);
    chk("clr_last_pulses", pulses, 1);
    chk("clr_last_in_pkt", in_pkt, 0);

    // random traffic with random patterns and sink_en gaps mid-packet
    pattern = 8'($urandom_range(1, 255));
    for (int p = 0; p < 12; p++) begin
      int len;
      len = $urandom_range(1, 5);
      if ($urandom_range(0, 3) == 0) pattern = 8'($urandom_range(1, 255));
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          sink_en = 1'b0;
          repeat ($urandom_range(1, 3)) @(posedge clk);
          @(negedge clk);
          chk("en_off_in_pkt", in_pkt, m_in_pkt);
          @(posedge clk);
          #1;
          sink_en = 1'b1;
        end
        send_beat(4'($urandom), b == len - 1, 1'($urandom));
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check_totals("random");

    // reset after 2 beats of a 5-beat packet, then a fresh 3-beat packet
    pattern = 8'hFF;
    send_beat(4'hF, 1'b0, 1'b0);
    send_beat(4'hF, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_in_pkt", in_pkt, 0);
    chk("mid_rst_pkt_cnt", pkt_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int b = 0; b < 3; b++) send_beat(4'hF, b == 2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_totals("after_rst");
    chk("after_rst_pkts", pkt_cnt, 1);
    chk("after_rst_len", last_pkt_len, 3);

    // saturation of the narrow-counter instance
    clear_s = 1'b1;
    @(posedge clk);
    s_beats = 0; s_bytes = 0; s_pkts = 0; s_users = 0;
    #1;
    clear_s = 1'b0;
    for (int p = 0; p < 20; p++) send_beat(4'hF, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sat_pkt_cnt", s_pkt_cnt, min15(s_pkts));
    chk("sat_beat_cnt", s_beat_cnt, min15(s_beats));
    chk("sat_byte_cnt", s_byte_cnt, min15(s_bytes));
    chk("sat_user_cnt", s_user_cnt, min15(s_users));
    chk("sat_last_len", s_last_pkt_len, 1);
    @(posedge clk);
    #1;
    check_totals("final");
    chk("sb_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/axis_slaver_sink.md
AXIS_SLAVER_SINK -- requirements
Module: axis_slaver_sink

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of every statistics counter.
REQ-002 SHALL have parameter LEN_W, default 16, width of the packet-length registers.
REQ-003 SHALL have port slaver.aclk  input  1  sole clock; all logic is rising-edge on it.
REQ-004 SHALL have port slaver.aresetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port slaver  axi_stream_inf.slaver  DSIZE/KSIZE from interface  upstream stream to consume; only tvalid, tready, tdata, tkeep, tlast, tuser are used.
REQ-006 SHALL have port sink_en  input  1  1 = accept traffic; 0 = tready forced low.
REQ-007 SHALL have port ready_pattern  input  8  backpressure mask; bit[phase] gates tready.
REQ-008 SHALL have port clear  input  1  synchronous clear of all statistics.
REQ-009 SHALL have port beat_cnt  output  CNT_W  accepted beats.
REQ-010 SHALL have port byte_cnt  output  CNT_W  accepted bytes (sum of set tkeep bits).
REQ-011 SHALL have port pkt_cnt  output  CNT_W  completed packets.
REQ-012 SHALL have port user_cnt  output  CNT_W  accepted beats with tuser[0]=1.
REQ-013 SHALL have port last_pkt_len  output  LEN_W  beat length of the most recent completed packet.
REQ-014 SHALL have port pkt_done  output  1  one-cycle pulse, cycle after a tlast beat is accepted.
REQ-015 SHALL have port in_pkt  output  1  1 while the FSM is in S_PKT.

Function
REQ-016 SHALL define an accepted beat as tvalid & tready at a rising edge; nothing else changes any counter.
REQ-017 SHALL keep a 3-bit phase counter that increments by 1 every cycle while sink_en=1, wraps 7->0, and holds while sink_en=0.
REQ-018 SHALL drive tready = sink_en & ready_pattern[phase], registered; it therefore reflects the phase and inputs of the previous cycle, and it SHALL NOT depend combinationally on tvalid.
REQ-019 SHALL run FSM S_IDLE/S_PKT: S_IDLE -> S_PKT on an accepted beat with tlast=0; S_PKT -> S_IDLE on an accepted beat with tlast=1; in all other cases the state holds.
REQ-020 SHALL, in either state, treat an accepted tlast=1 beat as ending a packet; a single-beat packet (S_IDLE, tlast=1) SHALL count with length 1.
REQ-021 SHALL hold a LEN_W cur_len: load 1 on the first beat of a packet, +1 on each further beat, and saturate at all-ones.
REQ-022 SHALL, on packet end: set last_pkt_len = final cur_len including the tlast beat; increment pkt_cnt; pulse pkt_done on the next cycle.
REQ-023 SHALL increment byte_cnt by popcount(tkeep) per accepted beat, with popcount computed over KSIZE bits.
REQ-024 SHALL saturate all CNT_W counters at all-ones and never wrap.
REQ-025 SHALL, on clear=1: zero beat_cnt, byte_cnt, pkt_cnt, user_cnt and last_pkt_len next cycle; a beat accepted in the same cycle is not counted; the FSM, cur_len and pkt_done still update normally.
REQ-026 SHALL NOT abort a packet when sink_en is deasserted mid-packet; the FSM stays in S_PKT and resumes when sink_en returns.
REQ-027 SHALL ignore tdata; it is consumed and discarded.

Reset
REQ-028 SHALL, while aresetn=0: tready=0, phase=0, state=S_IDLE, every counter, cur_len and last_pkt_len=0, pkt_done=0, in_pkt=0.
REQ-029 SHALL, on reset mid-packet, discard the partial packet; the next beat after release starts a new packet.
REQ-030 SHALL drive tready high no earlier than the second rising edge after aresetn deasserts.

Verification
REQ-031 SHALL cover: sink_en=1, pattern=8'hFF, 3 packets of 4 beats, tkeep all-ones, DSIZE=32 -> beat_cnt=12, byte_cnt=48, pkt_cnt=3, last_pkt_len=4, 3 pkt_done pulses.
REQ-032 SHALL cover: pattern=8'h55, continuous tvalid -> tready toggles every cycle, and exactly 4 beats are accepted per 8 cycles.
REQ-033 SHALL cover: single-beat packet with tkeep=4'b0011, then a 2-beat packet with tuser[0]=1 on beat 2 -> pkt_cnt=2, last_pkt_len=2, byte_cnt=2+8, user_cnt=1.
REQ-034 SHALL cover: clear coincident with an accepted tlast beat -> all counters 0, pkt_done still pulses, state=S_IDLE.
REQ-035 SHALL cover: aresetn low after 2 beats of a 5-beat packet, then a new 3-beat packet -> pkt_cnt=1, last_pkt_len=3.
REQ-036 SHALL cover: CNT_W=4, 20 single-beat packets -> pkt_cnt and beat_cnt saturate at 15.
